mem_stage_ctrl: RTL and testbench

Memory-stage access controller on the far side of the EX/MEM pipeline register. It accepts the register's load/store control and operands, performs the access on a ready/ack data-memory port, and drives the stall signal back to the pipeline registers until the access completes. It returns load data toward MEM/WB and holds it stable.

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_stage_wbuf.sv | 40 ++++
 rtl/mem_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-stage access controller.
// The DRAIN state is only reachable when MEM_STAGE_WBUF_EN is defined.
package mem_stage_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } memState_e;

endpackage

// File: rtl/mem_stage_wbuf.sv
// One-entry posted write buffer (valid, addr, data) for mem_stage_ctrl.
// Compiled only when MEM_STAGE_WBUF_EN is defined.
`ifdef MEM_STAGE_WBUF_EN
module mem_stage_wbuf
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0] pushData,
    output logic              valid,
    output logic [ADDR_W-1:0] bufAddr,
    output logic [DATA_W-1:0] bufData
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately not reset; it is ignored while valid is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            bufAddr <= pushAddr;
            bufData <= pushData;
        end
    end

endmodule
`endif

// File: rtl/mem_stage_ctrl.sv
// Memory-stage load/store controller: issues EX/MEM accesses on a req/ack port and stalls the pipe.
// Define MEM_STAGE_WBUF_EN to add a one-entry posted write buffer (stores retire without stalling).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wrData_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdData_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    memState_e         state, stateNext;
    logic              access;
    logic              bufLoad;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;

    assign access = memRead_i | memWrite_i;

`ifdef MEM_STAGE_WBUF_EN
    logic              bufClear;
    logic              bufValid;
    logic [ADDR_W-1:0] bufAddr;
    logic [DATA_W-1:0] bufData;

    mem_stage_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (bufLoad),
        .pop      (bufClear),
        .pushAddr (addr_i),
        .pushData (wrData_i),
        .valid    (bufValid),
        .bufAddr  (bufAddr),
        .bufData  (bufData)
    );

    assign mem_addr_o  = (state == DRAIN) ? bufAddr : addrQ;
    assign mem_wdata_o = (state == DRAIN) ? bufData : wdataQ;
`else
    assign mem_addr_o  = addrQ;
    assign mem_wdata_o = wdataQ;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        stateNext = state;
        stall_o   = 1'b0;
        bufLoad   = 1'b0;
`ifdef MEM_STAGE_WBUF_EN
        bufClear  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (access) begin
`ifdef MEM_STAGE_WBUF_EN
                    if (memWrite_i && !bufValid) begin
                        bufLoad   = 1'b1;
                        stateNext = DRAIN;
                    end else begin
                        stall_o   = 1'b1;
                        stateNext = WAIT;
                    end
`else
                    stall_o   = 1'b1;
                    stateNext = WAIT;
`endif
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem_ack_i) stateNext = DONE;
            end
            // The held instruction leaves at this edge; inputs are not looked at here.
            DONE: stateNext = IDLE;
`ifdef MEM_STAGE_WBUF_EN
            DRAIN: begin
                stall_o = access;
                if (mem_ack_i) begin
                    bufClear  = 1'b1;
                    stateNext = IDLE;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state-holding registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdData_o  <= '0;
        end else if (state == IDLE && access) begin
            mem_req_o <= 1'b1;
            mem_we_o  <= memWrite_i;
            if (!bufLoad) begin
                addrQ  <= addr_i;
                wdataQ <= wrData_i;
            end
        end else if (mem_ack_i && (state == WAIT || state == DRAIN)) begin
            mem_req_o <= 1'b0;
            if (state == WAIT && !mem_we_o) rdData_o <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, randomized accesses
// against a transaction-level memory model, reset-mid-access and (MEM_STAGE_WBUF_EN) drain cases.
module tb_mem_stage_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          memRead_i, memWrite_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wrData_i;
    logic          stall_o;
    logic [DW-1:0] rdData_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .memRead_i   (memRead_i),
        .memWrite_i  (memWrite_i),
        .addr_i      (addr_i),
        .wrData_i    (wrData_i),
        .stall_o     (stall_o),
        .rdData_o    (rdData_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // request cycles until ack (1 = ack in first WAIT cycle)
        logic [31:0] rdat;
        int          expStall;
        logic [31:0] expRd;
    } vec_t;

    logic [31:0] memModel [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents one instruction as the pipeline would, acts as the memory, and reports what
    // the controller did. Called aligned to posedge+1, returns aligned to posedge+1.
    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rdat, input int lat,
                             output int stalls, output int bursts, output logic [31:0] rAddr,
                             output logic [31:0] rData, output logic rWe,
                             output logic [31:0] rdAtDone, output bit timedOut);
        int  reqCnt;
        bit  prevReq;
        bit  done;
        memRead_i   = rd;
        memWrite_i  = wr;
        addr_i      = a;
        wrData_i    = d;
        mem_rdata_i = rdat;
        stalls = 0; bursts = 0; reqCnt = 0; prevReq = 1'b0; done = 1'b0;
        rAddr = '0; rData = '0; rWe = 1'b0; rdAtDone = '0; timedOut = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (mem_req_o) begin
                reqCnt++;
                if (!prevReq) begin
                    bursts++;
                    rAddr = mem_addr_o;
                    rData = mem_wdata_o;
                    rWe   = mem_we_o;
                end
            end
            prevReq   = mem_req_o;
            mem_ack_i = mem_req_o && (reqCnt == lat);
            @(negedge clk_i);
            if (!stall_o) begin
                done     = 1'b1;
                rdAtDone = rdData_o;
            end else begin
                stalls++;
            end
            @(posedge clk_i);
            #1;
            if (done) break;
        end
        mem_ack_i  = 1'b0;
        memRead_i  = 1'b0;
        memWrite_i = 1'b0;
        timedOut   = !done;
    endtask

    task automatic checkAccess(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d, input int lat,
                               input logic [31:0] expRd);
        int          stalls, bursts;
        logic [31:0] rAddr, rData, rdAtDone;
        logic        rWe;
        bit          timedOut;
        bit          acc;
        logic [31:0] rdat;
        acc  = rd | wr;
        rdat = memModel.exists(a) ? memModel[a] : ~a;
        runAccess(rd, wr, a, d, rdat, lat, stalls, bursts, rAddr, rData, rWe, rdAtDone, timedOut);
        check({tag, "_timeout"}, 32'(timedOut), 32'd0);
        check({tag, "_stall"}, 32'(stalls), acc ? 32'(lat + 1) : 32'd0);
        check({tag, "_bursts"}, 32'(bursts), acc ? 32'd1 : 32'd0);
        if (acc) begin
            check({tag, "_addr"}, rAddr, a);
            check({tag, "_we"}, 32'(rWe), 32'(wr));
        end
        if (wr) check({tag, "_wdata"}, rData, d);
        check({tag, "_rddata"}, rdAtDone, expRd);
    endtask

    initial begin
        vec_t        tbl [7];
        logic [31:0] expRd;

        rst_i = 1'b1; memRead_i = 1'b0; memWrite_i = 1'b0; addr_i = '0; wrData_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_req", 32'(mem_req_o), 32'd0);
        check("reset_we", 32'(mem_we_o), 32'd0);
        check("reset_addr", mem_addr_o, 32'd0);
        check("reset_wdata", mem_wdata_o, 32'd0);
        check("reset_rddata", rdData_o, 32'd0);
        @(posedge clk_i);
        #1;

`ifndef MEM_STAGE_WBUF_EN
        //            rd    wr    addr          wdata         lat rdat          stall expRd
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        3, 32'hDEADBEEF, 4, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_1234, 1, 32'hFFFF_FFFF, 2, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1, 32'h1111_1111, 2, 32'h1111_1111};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        1, 32'h2222_2222, 2, 32'h2222_2222};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0009, 1, 32'hAAAA_5555, 2, 32'h2222_2222};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0099, 32'h0000_0077, 1, 32'h3333_3333, 0, 32'h2222_2222};
        tbl[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        5, 32'h0000_0000, 6, 32'h0000_0000};
        foreach (tbl[i]) begin
            int          stalls, bursts;
            logic [31:0] rAddr, rData, rdAtDone;
            logic        rWe;
            bit          timedOut;
            runAccess(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdat, tbl[i].lat,
                      stalls, bursts, rAddr, rData, rWe, rdAtDone, timedOut);
            check($sformatf("tbl%0d_timeout", i), 32'(timedOut), 32'd0);
            check($sformatf("tbl%0d_stall", i), 32'(stalls), 32'(tbl[i].expStall));
            check($sformatf("tbl%0d_bursts", i), 32'(bursts), (tbl[i].rd | tbl[i].wr) ? 32'd1 : 32'd0);
            if (tbl[i].rd | tbl[i].wr) begin
                check($sformatf("tbl%0d_addr", i), rAddr, tbl[i].addr);
                check($sformatf("tbl%0d_we", i), 32'(rWe), 32'(tbl[i].wr));
            end
            if (tbl[i].wr) check($sformatf("tbl%0d_wdata", i), rData, tbl[i].wdata);
            check($sformatf("tbl%0d_rddata", i), rdAtDone, tbl[i].expRd);
        end

        // Random mix against a word-addressed memory model; unwritten words read as ~addr.
        expRd = tbl[6].expRd;
        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic        rd, wr;
            logic [31:0] a, d;
            int          lat;
            kind = int'($urandom_range(0, 9));
            rd   = (kind < 4) || (kind == 8);
            wr   = (kind >= 4 && kind < 8) || (kind == 8);
            a    = 32'($urandom_range(0, 31)) << 2;
            d    = $urandom;
            lat  = int'($urandom_range(1, 4));
            if (rd && !wr) expRd = memModel.exists(a) ? memModel[a] : ~a;
            checkAccess($sformatf("rnd%0d", n), rd, wr, a, d, lat, expRd);
            if (wr) memModel[a] = d;
        end
`else
        checkAccess("load0", 1'b1, 1'b0, 32'h40, 32'h0, 3, ~32'h40);

        // Store posts into the buffer, a load of the same address waits for the drain ack.
        memWrite_i = 1'b1; addr_i = 32'h20; wrData_i = 32'h55;
        @(negedge clk_i);
        check("wb_store_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        memWrite_i = 1'b0; memRead_i = 1'b1; addr_i = 32'h20; wrData_i = 32'h0;
        check("wb_drain_req", 32'(mem_req_o), 32'd1);
        check("wb_drain_we", 32'(mem_we_o), 32'd1);
        check("wb_drain_addr", mem_addr_o, 32'h20);
        check("wb_drain_wdata", mem_wdata_o, 32'h55);
        @(negedge clk_i);
        check("wb_load_stall0", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1 mem_ack_i = 1'b1;
        @(negedge clk_i);
        check("wb_load_stall1", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        check("wb_req_dropped", 32'(mem_req_o), 32'd0);
        @(negedge clk_i);
        check("wb_load_stall2", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1;
        check("wb_load_req", 32'(mem_req_o), 32'd1);
        check("wb_load_we", 32'(mem_we_o), 32'd0);
        check("wb_load_addr", mem_addr_o, 32'h20);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("wb_done_stall", 32'(stall_o), 32'd0);
        check("wb_done_rddata", rdData_o, 32'h77);
        @(posedge clk_i);
        #1 memRead_i = 1'b0;
`endif

        // Reset while waiting for an ack: the access is dropped and the late ack ignored.
        memRead_i = 1'b1; addr_i = 32'h40;
        @(posedge clk_i);
        #1 check("rst_req_before", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0; memRead_i = 1'b0;
        check("rst_req_after", 32'(mem_req_o), 32'd0);
        check("rst_rddata_after", rdData_o, 32'd0);
        @(posedge clk_i);
        #1 mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        check("rst_late_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        check("rst_late_ack_rddata", rdData_o, 32'd0);
        check("rst_late_ack_req", 32'(mem_req_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
